// File: rtl/cla_nibble_sequencer.sv
// Wide adder that feeds one 4-bit carry-lookahead slice a nibble per clock,
// LSB nibble first, with the inter-slice carry held in a register.

module cla_nibble_sequencer_slice (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c3_o,
    output logic       c4_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = x_i & y_i;
    assign p = x_i ^ y_i;

    assign c1   = g[0] | (p[0] & c_i);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c3_o = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_i);
    assign s_o  = p ^ {c3_o, c2, c1, c_i};
endmodule

module cla_nibble_sequencer #(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0] s_nib;
    logic       s_c3;
    logic       s_c4;

    cla_nibble_sequencer_slice u_slice (
        .x_i  (a_q[{idx_q, 2'b00} +: 4]),
        .y_i  (b_q[{idx_q, 2'b00} +: 4]),
        .c_i  (carry_q),
        .s_o  (s_nib),
        .c3_o (s_c3),
        .c4_o (s_c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = s_nib;
                carry_d = s_c4;
                idx_d   = idx_q + IW'(1);
                // Top slice: its carry-in to bit 3 is the carry into the MSB
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = s_c4;
                    ovf_d   = s_c3 ^ s_c4;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed and random checks of the nibble-serial lookahead adder.

module tb_cla_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cla_nibble_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One transaction: accept, wait for result, hold off `hold` cycles, drain
    task automatic xact(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input int hold,
                        input logic [15:0] es, input logic ec,
                        input logic eo, input logic poke);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        a = xa;
        b = xb;
        cin = xc;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = poke;
        a = ~xa;
        b = xb ^ 16'h5A5A;
        cin = ~xc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (poke) begin
                chk("in_ready_run", {31'b0, in_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 32'd4);
        chk("sum", {16'b0, sum}, {16'b0, es});
        chk("cout", {31'b0, cout}, {31'b0, ec});
        chk("ovf", {31'b0, ovf}, {31'b0, eo});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_rdy", {31'b0, in_ready}, 32'd0);
            chk("hold_sum", {15'b0, cout, sum}, {15'b0, ec, es});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_hold", {14'b0, eo, ec, sum}, {14'b0, eo, ec, es});
    endtask

    initial begin
        logic [16:0] full;
        logic [15:0] ra, rb;
        logic        rc, rovf;

        #12;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", {14'b0, ovf, cout, sum}, 32'd0);
        rst_n = 1'b1;

        xact(16'h0001, 16'h0000, 1'b0, 0, 16'h0001, 1'b0, 1'b0, 1'b0);
        xact(16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0, 1'b0);
        xact(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, 1'b0);
        xact(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0);
        xact(16'h00B5, 16'h0063, 1'b1, 10, 16'h0119, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out", {14'b0, ovf, cout, sum}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xact(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            xact(ra, rb, rc, int'($urandom_range(0, 3)),
                 full[15:0], full[16], rovf, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
